// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN input path.
// FSM state enum, neuron width constant, signed saturation.
package snn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int NEURON_INPUT_WIDTH = 8;

  // Clamp x into the signed range of a w-bit value.
  function automatic logic signed [31:0] sat(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      sat = hi;
    else if (x < lo) sat = lo;
    else             sat = x;
  endfunction

endpackage

// File: rtl/snn_weight_regfile.sv
// Signed synaptic weight storage: one write port, one
// clear-index zeroing port, all weights read in parallel.
module snn_weight_regfile #(
  parameter int N  = 8,
  parameter int WW = 8,
  parameter int AW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WW-1:0]        wdata,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_idx,
  output logic [N-1:0][WW-1:0] weights
);

  logic addr_ok;
  assign addr_ok = {1'b0, waddr} < (AW+1)'(N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights <= '0;
    end else begin
      if (we && addr_ok) weights[waddr] <= wdata;
      if (clr_en)        weights[clr_idx] <= '0;
    end
  end

endmodule

// File: rtl/snn_synapse_integrator.sv
// Spike vector -> weighted sum -> decaying saturated current.
// Ports: spike_in, weight write (valid/ready), clear, current_out.
module snn_synapse_integrator
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ACC_WIDTH     = 16,
  parameter int CURRENT_WIDTH = NEURON_INPUT_WIDTH,
  parameter int SYN_DECAY     = 2,
  localparam int AW = $clog2(NUM_INPUTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_INPUTS-1:0]    spike_in,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]  wr_data,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic [CURRENT_WIDTH-1:0] current_out
);

  state_t  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic    clr_en;
  logic    start_clr;
  logic    we;

  logic [NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0] weights;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic signed [ACC_WIDTH-1:0] syn_q;
  logic signed [ACC_WIDTH-1:0] syn_d;
  logic signed [ACC_WIDTH+1:0] nxt;

  assign clear_busy = (state_q == CLEAR);
  assign wr_ready   = (state_q == IDLE) && !clear_req;
  assign start_clr  = (state_q == IDLE) && clear_req;
  assign we         = wr_valid && wr_ready;

  snn_weight_regfile #(
    .N  (NUM_INPUTS),
    .WW (WEIGHT_WIDTH),
    .AW (AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .clr_en  (clr_en),
    .clr_idx (idx_q),
    .weights (weights)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == AW'(NUM_INPUTS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spike_in[i])
        acc = acc + ACC_WIDTH'($signed(weights[i]));
    end
  end

  // Headroom of two bits so the decay and add never wrap
  // before the clamp.
  always_comb begin
    nxt = (ACC_WIDTH+2)'(syn_q)
        - (ACC_WIDTH+2)'(syn_q >>> SYN_DECAY)
        + (ACC_WIDTH+2)'(sum_q);
    syn_d = ACC_WIDTH'(sat(32'(nxt), ACC_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      syn_q <= '0;
    end else begin
      if (start_clr || clear_busy) sum_q <= '0;
      else                         sum_q <= acc;
      if (start_clr) syn_q <= '0;
      else           syn_q <= syn_d;
    end
  end

  assign current_out =
    CURRENT_WIDTH'(sat(32'(syn_q), CURRENT_WIDTH));

endmodule

// File: tb/tb_snn_synapse_integrator.sv
// Self-checking bench for snn_synapse_integrator.
// Vector table, directed corner sequences, random vs model.
module tb_snn_synapse_integrator;

  localparam int N  = 8;
  localparam int WW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  spike_in = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic [7:0]    current_out;

  int checks = 0;
  int errors = 0;

  snn_synapse_integrator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .current_out (current_out)
  );

  always #5 clk = ~clk;

  int m_w[N];
  int m_sum;
  int m_syn;
  bit m_busy;
  int m_idx;

  function automatic int fdiv(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clampw(int v, int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_w[i] = 0;
    m_sum = 0;
    m_syn = 0;
    m_busy = 1'b0;
    m_idx = 0;
  endtask

  // One clock edge of the behaviour, using the inputs present now.
  task automatic m_edge();
    int ns;
    int nsyn;
    bit start;
    nsyn = clampw(m_syn - fdiv(m_syn, 4) + m_sum, 16);
    start = !m_busy && clear_req;
    ns = 0;
    if (!m_busy && !start)
      for (int i = 0; i < N; i++)
        if (spike_in[i]) ns += m_w[i];
    if (start) begin
      nsyn = 0;
      m_busy = 1'b1;
      m_idx = 0;
    end else if (m_busy) begin
      m_w[m_idx] = 0;
      m_idx++;
      if (m_idx == N) m_busy = 1'b0;
    end else if (wr_valid) begin
      m_w[wr_addr] = int'($signed(wr_data));
    end
    m_sum = ns;
    m_syn = nsyn;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cur();
    return int'($signed(current_out));
  endfunction

  task automatic chk_model(string tag);
    chk({tag, "_cur"}, cur(), clampw(m_syn, 8));
    chk({tag, "_busy"}, int'(clear_busy), int'(m_busy));
    chk({tag, "_rdy"}, int'(wr_ready),
        int'(!m_busy && !clear_req));
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    chk_model("mdl");
  endtask

  task automatic idle_in();
    spike_in = '0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clear_req = 1'b0;
  endtask

  task automatic do_reset(string tag);
    idle_in();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk({tag, "_rst_cur"}, cur(), 0);
    chk({tag, "_rst_busy"}, int'(clear_busy), 0);
    chk({tag, "_rst_rdy"}, int'(wr_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(int a, int d);
    wr_valid = 1'b1;
    wr_addr = AW'(a);
    wr_data = WW'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  spk;
    logic          wv;
    logic [AW-1:0] wa;
    logic [WW-1:0] wd;
    int            cur;
  } vec_t;

  vec_t tbl[10];
  int   nb;
  int   nr;

  initial begin
    tbl[0] = '{8'h00, 1'b1, 3'd0, 8'd10, 0};
    tbl[1] = '{8'h01, 1'b0, 3'd0, 8'd0, 0};
    tbl[2] = '{8'h00, 1'b0, 3'd0, 8'd0, 10};
    tbl[3] = '{8'h00, 1'b0, 3'd0, 8'd0, 8};
    tbl[4] = '{8'h00, 1'b0, 3'd0, 8'd0, 6};
    tbl[5] = '{8'h00, 1'b0, 3'd0, 8'd0, 5};
    tbl[6] = '{8'h00, 1'b0, 3'd0, 8'd0, 4};
    tbl[7] = '{8'h00, 1'b0, 3'd0, 8'd0, 3};
    tbl[8] = '{8'h00, 1'b0, 3'd0, 8'd0, 3};
    tbl[9] = '{8'h00, 1'b0, 3'd0, 8'd0, 3};

    m_reset();
    #12;
    chk("por_cur", cur(), 0);
    chk("por_busy", int'(clear_busy), 0);
    chk("por_rdy", int'(wr_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single weight, single spike, decay tail.
    for (int i = 0; i < 10; i++) begin
      spike_in = tbl[i].spk;
      wr_valid = tbl[i].wv;
      wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd;
      tick();
      chk($sformatf("tbl%0d_cur", i), cur(), tbl[i].cur);
      chk($sformatf("tbl%0d_rdy", i), int'(wr_ready), 1);
    end
    idle_in();

    // Negative weight.
    do_reset("neg");
    wr(1, -128);
    spike_in = 8'h02;
    tick();
    chk("neg_lat", cur(), 0);
    spike_in = '0;
    tick();
    chk("neg_0", cur(), -128);
    tick();
    chk("neg_1", cur(), -96);
    tick();
    chk("neg_2", cur(), -72);
    tick();
    chk("neg_3", cur(), -54);
    for (int i = 0; i < 30; i++) tick();

    // All weights max, all spikes held: output pinned at max.
    do_reset("sat");
    for (int i = 0; i < N; i++) wr(i, 127);
    spike_in = '1;
    tick();
    chk("sat_lat", cur(), 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), cur(), 127);
    end
    idle_in();

    // Write and spike to the same weight on one edge.
    do_reset("col");
    wr(2, 20);
    spike_in = 8'h04;
    wr_valid = 1'b1;
    wr_addr = 3'd2;
    wr_data = 8'd50;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("col_old", cur(), 20);
    spike_in = '0;
    tick();
    chk("col_new", cur(), 65);

    // Clear wins over a simultaneous write.
    do_reset("clr");
    for (int i = 0; i < N; i++) wr(i, 5 + i);
    spike_in = '1;
    tick();
    tick();
    tick();
    clear_req = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'd99;
    #1;
    chk("clr_rdy_lo", int'(wr_ready), 0);
    tick();
    chk("clr_cur0", cur(), 0);
    clear_req = 1'b0;
    wr_valid = 1'b0;
    nb = clear_busy ? 1 : 0;
    nr = wr_ready ? 0 : 1;
    for (int k = 0; k < 20 && clear_busy; k++) begin
      if (k == 3) clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      if (clear_busy) nb++;
      if (!wr_ready) nr++;
    end
    chk("clr_busy_len", nb, N);
    chk("clr_rdy_len", nr, N);
    chk("clr_rdy_back", int'(wr_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("clr_zero%0d", i), cur(), 0);
    end
    idle_in();

    // Reset during a write with a live current.
    do_reset("mw0");
    wr(3, 60);
    spike_in = 8'h08;
    tick();
    tick();
    wr_valid = 1'b1;
    wr_addr = 3'd5;
    wr_data = 8'd77;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mw_cur", cur(), 0);
    chk("mw_busy", int'(clear_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();
    spike_in = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mw_zero%0d", i), cur(), 0);
    end
    idle_in();

    // Reset in the middle of a clear.
    do_reset("mc0");
    wr(0, 33);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    tick();
    chk("mc_busy_pre", int'(clear_busy), 1);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mc_busy", int'(clear_busy), 0);
    chk("mc_rdy", int'(wr_ready), 1);
    chk("mc_cur", cur(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    spike_in = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mc_zero%0d", i), cur(), 0);
    end

    // Random traffic against the model.
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      spike_in = N'($urandom);
      wr_valid = ($urandom_range(3) == 0);
      wr_addr = AW'($urandom);
      wr_data = WW'($urandom);
      clear_req = ($urandom_range(49) == 0);
      tick();
    end
    idle_in();
    for (int i = 0; i < 40; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
